rf_arbiter: RTL and testbench

RF_ARBITER -- requirements
Module: rf_arbiter

---
 rtl/rf_arbiter_if.sv | 31 +++
 rtl/rf_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_arbiter_if.sv
// Bus bundle between two requesters, the round-robin arbiter and a shared register file.
// The master view is the requester/register-file side; the slave view is the arbiter.
interface rf_arbiter_if #(
   parameter int D_WIDTH = 8,
   parameter int ADDRESS = 4
);
   logic [1:0]                req;
   logic [1:0]                wr;
   logic [1:0][ADDRESS-1:0]   addr;
   logic [1:0][D_WIDTH-1:0]   wdata;
   logic [1:0]                ack;
   logic [1:0][D_WIDTH-1:0]   rdata;
   logic [1:0]                err;
   logic                      rf_wr_en;
   logic                      rf_rd_en;
   logic [ADDRESS-1:0]        rf_address;
   logic [D_WIDTH-1:0]        rf_wr_data;
   logic [D_WIDTH-1:0]        rf_rd_data;
   logic                      rf_rd_data_vld;
   logic                      busy;

   modport master (
      output req, wr, addr, wdata, rf_rd_data, rf_rd_data_vld,
      input  ack, rdata, err, rf_wr_en, rf_rd_en, rf_address, rf_wr_data, busy
   );

   modport slave (
      input  req, wr, addr, wdata, rf_rd_data, rf_rd_data_vld,
      output ack, rdata, err, rf_wr_en, rf_rd_en, rf_address, rf_wr_data, busy
   );
endinterface

// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file,
// with a bounded read wait that reports a timeout error to the requester.
//
// state | meaning
// IDLE  | sample requests, grant one, drive the register-file strobe
// ISSUE | strobe cycle; writes finish here, reads go on to WAIT
// WAIT  | count cycles until read-valid or TIMEOUT expires
// RESP  | one-cycle ACK to the granted requester
module rf_arbiter #(
   parameter int D_WIDTH = 8,
   parameter int ADDRESS = 4,
   parameter int TIMEOUT = 15
) (
   input logic        clk,
   input logic        rst,
   rf_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                  state, state_n;
   logic                    gnt, gnt_n;
   logic                    ptr, ptr_n;
   logic                    lat_wr, lat_wr_n;
   logic [7:0]              cnt, cnt_n;
   logic                    pick;
   logic [1:0]              ack_n, err_n;
   logic [1:0][D_WIDTH-1:0] rdata_n;
   logic                    rf_wr_en_n, rf_rd_en_n, busy_n;
   logic [ADDRESS-1:0]      rf_address_n;
   logic [D_WIDTH-1:0]      rf_wr_data_n;

   // A lone requester wins outright; the pointer only breaks ties.
   assign pick = (bus.req[0] & bus.req[1]) ? ptr : ~bus.req[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         gnt            <= 1'b0;
         ptr            <= 1'b0;
         lat_wr         <= 1'b0;
         cnt            <= '0;
         bus.ack        <= '0;
         bus.rdata      <= '0;
         bus.err        <= '0;
         bus.rf_wr_en   <= 1'b0;
         bus.rf_rd_en   <= 1'b0;
         bus.rf_address <= '0;
         bus.rf_wr_data <= '0;
         bus.busy       <= 1'b0;
      end else begin
         state          <= state_n;
         gnt            <= gnt_n;
         ptr            <= ptr_n;
         lat_wr         <= lat_wr_n;
         cnt            <= cnt_n;
         bus.ack        <= ack_n;
         bus.rdata      <= rdata_n;
         bus.err        <= err_n;
         bus.rf_wr_en   <= rf_wr_en_n;
         bus.rf_rd_en   <= rf_rd_en_n;
         bus.rf_address <= rf_address_n;
         bus.rf_wr_data <= rf_wr_data_n;
         bus.busy       <= busy_n;
      end
   end

   // Outputs are computed for the state being entered so that every port is a flop.
   always_comb begin
      state_n      = state;
      gnt_n        = gnt;
      ptr_n        = ptr;
      lat_wr_n     = lat_wr;
      cnt_n        = cnt;
      ack_n        = '0;
      rdata_n      = '0;
      err_n        = '0;
      rf_wr_en_n   = 1'b0;
      rf_rd_en_n   = 1'b0;
      rf_address_n = '0;
      rf_wr_data_n = '0;

      case (state)
         IDLE: begin
            if (|bus.req) begin
               gnt_n        = pick;
               ptr_n        = ~pick;
               lat_wr_n     = bus.wr[pick];
               rf_wr_en_n   = bus.wr[pick];
               rf_rd_en_n   = ~bus.wr[pick];
               rf_address_n = bus.addr[pick];
               rf_wr_data_n = bus.wdata[pick];
               state_n      = ISSUE;
            end
         end
         ISSUE: begin
            if (lat_wr) begin
               ack_n[gnt] = 1'b1;
               state_n    = RESP;
            end else begin
               cnt_n   = '0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (bus.rf_rd_data_vld) begin
               ack_n[gnt]   = 1'b1;
               rdata_n[gnt] = bus.rf_rd_data;
               state_n      = RESP;
            end else if (cnt == CNT_LAST) begin
               ack_n[gnt] = 1'b1;
               err_n[gnt] = 1'b1;
               state_n    = RESP;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: write, read, round-robin, timeout, late valid, reset abort.
module tb_rf_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   rf_arbiter_if #(.D_WIDTH(8), .ADDRESS(4)) bus ();

   rf_arbiter #(.D_WIDTH(8), .ADDRESS(4), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int m, input logic r, input logic w,
                          input logic [3:0] a, input logic [7:0] d);
      bus.req[m]   = r;
      bus.wr[m]    = w;
      bus.addr[m]  = a;
      bus.wdata[m] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data, bus.ack, bus.err, bus.rdata} !== 35'h0) begin
         bad++;
         $display("FAIL reset_hold: got %h want 0", {bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data, bus.ack, bus.err, bus.rdata});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.ack, bus.err} !== 7'h0) begin
         bad++;
         $display("FAIL reset_idle: got %b want 0", {bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.ack, bus.err});
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 4'd3, 8'h5A);
      @(negedge clk);
      total++;
      if ({bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data} !== {1'b1, 1'b0, 4'd3, 8'h5A}) begin
         bad++;
         $display("FAIL wr_issue: got %h want %h", {bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data}, {1'b1, 1'b0, 4'd3, 8'h5A});
      end
      total++;
      if ({bus.busy, bus.ack} !== 3'b100) begin
         bad++;
         $display("FAIL wr_issue_busy: got %b want 100", {bus.busy, bus.ack});
      end
      @(negedge clk);
      total++;
      if ({bus.ack, bus.err, bus.rdata} !== {2'b01, 2'b00, 16'h0000}) begin
         bad++;
         $display("FAIL wr_ack: got %h want %h", {bus.ack, bus.err, bus.rdata}, {2'b01, 2'b00, 16'h0000});
      end
      set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      total++;
      if ({bus.busy, bus.ack, bus.rf_wr_en} !== 4'b0000) begin
         bad++;
         $display("FAIL wr_idle: got %b want 0000", {bus.busy, bus.ack, bus.rf_wr_en});
      end
   endtask

   task automatic test_read();
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
      @(negedge clk);
      total++;
      if ({bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data} !== {1'b0, 1'b1, 4'd7, 8'h00}) begin
         bad++;
         $display("FAIL rd_issue: got %h want %h", {bus.rf_wr_en, bus.rf_rd_en, bus.rf_address, bus.rf_wr_data}, {1'b0, 1'b1, 4'd7, 8'h00});
      end
      bus.rf_rd_data_vld = 1'b1;
      bus.rf_rd_data     = 8'hC3;
      @(negedge clk);
      total++;
      if ({bus.busy, bus.ack, bus.rf_rd_en} !== 4'b1000) begin
         bad++;
         $display("FAIL rd_wait: got %b want 1000", {bus.busy, bus.ack, bus.rf_rd_en});
      end
      @(negedge clk);
      total++;
      if ({bus.ack, bus.err, bus.rdata} !== {2'b10, 2'b00, 8'hC3, 8'h00}) begin
         bad++;
         $display("FAIL rd_ack: got %h want %h", {bus.ack, bus.err, bus.rdata}, {2'b10, 2'b00, 8'hC3, 8'h00});
      end
      bus.rf_rd_data_vld = 1'b0;
      bus.rf_rd_data     = 8'h00;
      set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      total++;
      if ({bus.busy, bus.ack} !== 3'b000) begin
         bad++;
         $display("FAIL rd_idle: got %b want 000", {bus.busy, bus.ack});
      end
   endtask

   task automatic test_round_robin();
      logic       m;
      logic [3:0] ea;
      logic [7:0] ed;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 4'd1, 8'h11);
      set_req(1, 1'b1, 1'b1, 4'd2, 8'h22);
      for (int g = 0; g < 4; g++) begin
         m  = (g % 2 == 1);
         ea = m ? 4'd2 : 4'd1;
         ed = m ? 8'h22 : 8'h11;
         @(negedge clk);
         total++;
         if ({bus.rf_wr_en, bus.rf_address, bus.rf_wr_data} !== {1'b1, ea, ed}) begin
            bad++;
            $display("FAIL rr_issue%0d: got %h want %h", g, {bus.rf_wr_en, bus.rf_address, bus.rf_wr_data}, {1'b1, ea, ed});
         end
         @(negedge clk);
         total++;
         if ({bus.ack, bus.err, bus.rdata} !== {(m ? 2'b10 : 2'b01), 2'b00, 16'h0000}) begin
            bad++;
            $display("FAIL rr_ack%0d: got %h want %h", g, {bus.ack, bus.err, bus.rdata}, {(m ? 2'b10 : 2'b01), 2'b00, 16'h0000});
         end
         @(negedge clk);
         total++;
         if ({bus.busy, bus.ack} !== 3'b000) begin
            bad++;
            $display("FAIL rr_idle%0d: got %b want 000", g, {bus.busy, bus.ack});
         end
      end
      // pointer is back on M0; a lone M1 request must still win
      set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      total++;
      if ({bus.rf_wr_en, bus.rf_address} !== {1'b1, 4'd2}) begin
         bad++;
         $display("FAIL rr_lone_issue: got %h want %h", {bus.rf_wr_en, bus.rf_address}, {1'b1, 4'd2});
      end
      @(negedge clk);
      total++;
      if (bus.ack !== 2'b10) begin
         bad++;
         $display("FAIL rr_lone_ack: got %b want 10", bus.ack);
      end
      set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
   endtask

   task automatic test_timeout();
      logic       eb, er;
      logic [1:0] ea;
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 4'd5, 8'h00);
      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         eb = (k <= 17);
         er = (k == 1);
         ea = (k == 17) ? 2'b01 : 2'b00;
         total++;
         if ({bus.busy, bus.rf_rd_en, bus.rf_wr_en, bus.ack, bus.err, bus.rdata} !== {eb, er, 1'b0, ea, ea, 16'h0000}) begin
            bad++;
            $display("FAIL timeout_n%0d: got %h want %h", k, {bus.busy, bus.rf_rd_en, bus.rf_wr_en, bus.ack, bus.err, bus.rdata}, {eb, er, 1'b0, ea, ea, 16'h0000});
         end
         if (k == 17) set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
         if (k == 20) begin
            bus.rf_rd_data_vld = 1'b1;
            bus.rf_rd_data     = 8'hEE;
         end
         if (k == 21) begin
            bus.rf_rd_data_vld = 1'b0;
            bus.rf_rd_data     = 8'h00;
         end
      end
   endtask

   task automatic test_vld_last();
      logic       eb;
      logic [1:0] ea;
      logic [7:0] ed;
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 4'd9, 8'h00);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         eb = (k <= 17);
         ea = (k == 17) ? 2'b10 : 2'b00;
         ed = (k == 17) ? 8'h77 : 8'h00;
         total++;
         if ({bus.busy, bus.ack, bus.err, bus.rdata} !== {eb, ea, 2'b00, ed, 8'h00}) begin
            bad++;
            $display("FAIL vld_last_n%0d: got %h want %h", k, {bus.busy, bus.ack, bus.err, bus.rdata}, {eb, ea, 2'b00, ed, 8'h00});
         end
         if (k == 16) begin
            bus.rf_rd_data_vld = 1'b1;
            bus.rf_rd_data     = 8'h77;
         end
         if (k == 17) begin
            bus.rf_rd_data_vld = 1'b0;
            bus.rf_rd_data     = 8'h00;
            set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 4'd6, 8'h00);
      repeat (2) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_wait_busy: got %b want 1", bus.busy);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.ack, bus.err, bus.rdata, bus.rf_address} !== 27'h0) begin
         bad++;
         $display("FAIL mid_reset: got %h want 0", {bus.busy, bus.rf_wr_en, bus.rf_rd_en, bus.ack, bus.err, bus.rdata, bus.rf_address});
      end
      set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.busy, bus.ack} !== 3'b000) begin
         bad++;
         $display("FAIL mid_no_ack: got %b want 000", {bus.busy, bus.ack});
      end
      set_req(0, 1'b1, 1'b1, 4'd1, 8'hA1);
      set_req(1, 1'b1, 1'b1, 4'd2, 8'hB2);
      @(negedge clk);
      total++;
      if ({bus.rf_wr_en, bus.rf_address, bus.rf_wr_data} !== {1'b1, 4'd1, 8'hA1}) begin
         bad++;
         $display("FAIL mid_regrant: got %h want %h", {bus.rf_wr_en, bus.rf_address, bus.rf_wr_data}, {1'b1, 4'd1, 8'hA1});
      end
      @(negedge clk);
      total++;
      if (bus.ack !== 2'b01) begin
         bad++;
         $display("FAIL mid_regrant_ack: got %b want 01", bus.ack);
      end
      set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.req            = '0;
      bus.wr             = '0;
      bus.addr           = '0;
      bus.wdata          = '0;
      bus.rf_rd_data     = '0;
      bus.rf_rd_data_vld = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_timeout();
      test_vld_last();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
